vscale_regfile_refresh: RTL and testbench
=========================================

Name: vscale_regfile_refresh

Overview:
- Share-refresh scheduler for the masked register file (SHARES shares of XPR_LEN bits per register).
- Periodically sweeps x1..x31: reads each register, XORs fresh randomness into its shares so the unmasked value is unchanged, and writes it back.
- Sits between the core pipeline and the register file. Owns the rf write port and read port 2, with the core given priority.
- Forces a core stall only when the refresh would otherwise starve.

Parameters:
- SHARES, 2, number of shares per register (at least 2).
- REFRESH_INTERVAL, 1024, idle cycles between sweeps; 0 = back-to-back sweeps.
- STARVE_LIMIT, 16, consecutive blocked cycles before core_stall is raised.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- enable  in  1  refresh enable
- core_ra2  in  5  core read address, port 2
- core_ra2_valid  in  1  core uses read port 2 this cycle
- core_wen  in  1  core writeback enable
- core_wa  in  5  core writeback address
- core_wd  in  XPR_LEN*SHARES  core writeback data
- rf_ra2  out  5  to regfile ra2
- rf_rd2  in  XPR_LEN*SHARES  from regfile rd2 (combinational read)
- rf_wen  out  1  to regfile wen
- rf_wa  out  5  to regfile wa
- rf_wd  out  XPR_LEN*SHARES  to regfile wd
- rnd  in  XPR_LEN*(SHARES-1)  fresh randomness
- rnd_valid  in  1  rnd available
- rnd_ready  out  1  rnd consumed this cycle
- core_stall  out  1  core must not use port 2 or the write port
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse when x31 is written back

Behaviour:
- Reset values:
  - state = IDLE, ptr = 1, interval counter = REFRESH_INTERVAL, wait counter = 0, data buffer = 0.
  - Outputs: core_stall = 0, busy = 0, sweep_done = 0, rnd_ready = 0.
  - Port muxes pass the core through.
- Port muxing (combinational):
  - rf_ra2 = ptr when the refresh owns the read port, else core_ra2.
  - rf_wen/rf_wa/rf_wd = refresh write when it fires, else the core signals.
  - The core always wins unless core_stall = 1.
- IDLE:
  - The interval counter decrements while enable = 1.
  - At 0 with enable = 1, go to RD, ptr = 1, busy = 1.
  - enable = 0 holds the counter.
- RD (read slot):
  - Slot taken when core_ra2_valid = 0 or core_stall = 1.
  - On a taken slot, capture rf_rd2 into the buffer and go to WR.
  - Hazard: if core_wen = 1 and core_wa == ptr in the same cycle, discard the capture and stay in RD.
- WR (write slot):
  - Fires when rnd_valid = 1 and (core_wen = 0 or core_stall = 1); rnd_ready = 1 in exactly that cycle.
  - Write data: share i = buf share i XOR rnd slice i for i < SHARES-1; last share = buf last share XOR (XOR of all rnd slices).
  - The XOR of all shares is therefore preserved.
  - Hazard: if the core writes ptr while in WR (write not fired), the buffer is stale; return to RD with the same ptr.
  - After the write fires: ptr increments. If ptr was 31, pulse sweep_done, reload the interval counter, set ptr = 1, clear busy, go to IDLE.
  - With REFRESH_INTERVAL = 0, the next sweep starts the following cycle.
- Starvation:
  - The wait counter increments each cycle in RD/WR where the slot is blocked by the core (not by rnd_valid = 0).
  - At STARVE_LIMIT, core_stall = 1 (registered) and stays high until the pending action completes; the counter clears on completion.
  - While core_stall = 1, core requests are ignored. It is the core's contract to hold them.
- enable deasserted:
  - In RD: go to IDLE immediately, ptr = 1, busy = 0, core_stall = 0.
  - In WR: the pending write completes, then go to IDLE.
- x0 is never read or written by the refresh; ptr ranges 1..31.
- Latency: minimum 2 cycles per register; minimum 62 cycles per uncontended sweep.
- Reset mid-sweep: immediate return to reset state. No partial write is issued, because rf_wen is combinational from state.

Test Plan:
- REFRESH_INTERVAL = 4, core idle, rnd_valid = 1, x5 = {0x1234_5678, 0} -> sweep starts at cycle 4.
  - 62 cycles later sweep_done pulses once.
  - The XOR of the two shares of every register is unchanged; share values differ from pre-sweep wherever rnd is nonzero.
- Core holds core_ra2_valid = 1 continuously with STARVE_LIMIT = 16 -> core_stall rises after 16 blocked cycles, falls after the RD capture, and re-rises on write contention.
- Refresh in WR for ptr = 7; core writes x7 = {0xAAAA_AAAA, 0x5555_5555} -> no refresh write to x7; RD of x7 is repeated; the final x7 share XOR = 0xFFFF_FFFF.
- rnd_valid = 0 for 20 cycles while in WR -> no write, rnd_ready = 0, core_stall stays 0; the write completes in the first cycle rnd_valid = 1.
- enable dropped while in RD at ptr = 10 -> IDLE next cycle, busy = 0. Re-enable -> after the interval, the sweep restarts at ptr = 1.
- Assert reset mid-WR -> rf_wen = 0 immediately; all outputs at reset values.

Source files
------------

// File: rtl/vscale_regfile_refresh.sv
// Share-refresh scheduler for the masked register file: sweeps x1..x31, re-randomising shares
// through the rf write port and read port 2 while yielding to the core until starvation forces a stall.
module vscale_regfile_refresh #(
   parameter int XPR_LEN          = 32,
   parameter int SHARES           = 2,
   parameter int REFRESH_INTERVAL = 1024,
   parameter int STARVE_LIMIT     = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [4:0]                    core_ra2,
   input  logic                          core_ra2_valid,
   input  logic                          core_wen,
   input  logic [4:0]                    core_wa,
   input  logic [XPR_LEN*SHARES-1:0]     core_wd,
   output logic [4:0]                    rf_ra2,
   input  logic [XPR_LEN*SHARES-1:0]     rf_rd2,
   output logic                          rf_wen,
   output logic [4:0]                    rf_wa,
   output logic [XPR_LEN*SHARES-1:0]     rf_wd,
   input  logic [XPR_LEN*(SHARES-1)-1:0] rnd,
   input  logic                          rnd_valid,
   output logic                          rnd_ready,
   output logic                          core_stall,
   output logic                          busy,
   output logic                          sweep_done
);
   localparam int W  = XPR_LEN*SHARES;
   localparam int IW = (REFRESH_INTERVAL > 0) ? $clog2(REFRESH_INTERVAL+1) : 1;
   localparam int SW = $clog2(STARVE_LIMIT+1);
   localparam logic [IW-1:0] INTERVAL_RELOAD = IW'(REFRESH_INTERVAL);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

   state_t          r_state;
   logic [4:0]      r_ptr;
   logic [IW-1:0]   r_interval;
   logic [SW-1:0]   r_wait;
   logic [W-1:0]    r_buf;
   logic            r_stall;
   logic            r_busy;
   logic            r_done;

   logic            w_core_wr;
   logic            w_ptr_hit;
   logic            w_rd_slot;
   logic            w_rd_cap;
   logic            w_wr_fire;
   logic            w_blocked;
   logic [XPR_LEN-1:0] w_rnd_acc;
   logic [W-1:0]    w_ref_wd;

   // A stalled core's requests are ignored, so they can neither block nor hazard the refresh.
   assign w_core_wr = core_wen & ~r_stall;
   assign w_ptr_hit = w_core_wr && (core_wa == r_ptr);
   assign w_rd_slot = (r_state == S_RD) && (!core_ra2_valid || r_stall);
   assign w_rd_cap  = w_rd_slot && !w_ptr_hit && enable;
   assign w_wr_fire = (r_state == S_WR) && rnd_valid && (!core_wen || r_stall);
   assign w_blocked = ((r_state == S_RD) && !r_stall && (core_ra2_valid || w_ptr_hit)) ||
                      ((r_state == S_WR) && !r_stall && core_wen);

   always_comb begin
      w_rnd_acc = '0;
      w_ref_wd  = r_buf;
      for (int i = 0; i < SHARES-1; i++) begin
         w_rnd_acc = w_rnd_acc ^ rnd[i*XPR_LEN +: XPR_LEN];
         w_ref_wd[i*XPR_LEN +: XPR_LEN] = r_buf[i*XPR_LEN +: XPR_LEN] ^ rnd[i*XPR_LEN +: XPR_LEN];
      end
      // Last share absorbs every mask so the XOR across shares is unchanged.
      w_ref_wd[(SHARES-1)*XPR_LEN +: XPR_LEN] = r_buf[(SHARES-1)*XPR_LEN +: XPR_LEN] ^ w_rnd_acc;
   end

   assign rf_ra2     = w_rd_slot ? r_ptr : core_ra2;
   assign rf_wen     = w_wr_fire | w_core_wr;
   assign rf_wa      = w_wr_fire ? r_ptr : core_wa;
   assign rf_wd      = w_wr_fire ? w_ref_wd : core_wd;
   assign rnd_ready  = w_wr_fire;
   assign core_stall = r_stall;
   assign busy       = r_busy;
   assign sweep_done = r_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ptr      <= 5'd1;
         r_interval <= INTERVAL_RELOAD;
         r_wait     <= '0;
         r_buf      <= '0;
         r_stall    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_blocked) begin
            if (r_wait >= SW'(STARVE_LIMIT-1)) r_stall <= 1'b1;
            if (r_wait != SW'(STARVE_LIMIT))   r_wait  <= r_wait + 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (enable) begin
                  if (r_interval == '0) begin
                     r_state <= S_RD;
                     r_ptr   <= 5'd1;
                     r_busy  <= 1'b1;
                  end else begin
                     r_interval <= r_interval - 1'b1;
                  end
               end
            end
            S_RD: begin
               if (!enable) begin
                  r_state    <= S_IDLE;
                  r_ptr      <= 5'd1;
                  r_busy     <= 1'b0;
                  r_stall    <= 1'b0;
                  r_wait     <= '0;
                  r_interval <= INTERVAL_RELOAD;
               end else if (w_rd_cap) begin
                  r_buf   <= rf_rd2;
                  r_state <= S_WR;
                  r_stall <= 1'b0;
                  r_wait  <= '0;
               end
            end
            S_WR: begin
               if (w_wr_fire) begin
                  r_stall <= 1'b0;
                  r_wait  <= '0;
                  if (r_ptr == 5'd31 || !enable) begin
                     r_state    <= S_IDLE;
                     r_ptr      <= 5'd1;
                     r_busy     <= 1'b0;
                     r_interval <= INTERVAL_RELOAD;
                     r_done     <= (r_ptr == 5'd31);
                  end else begin
                     r_ptr   <= r_ptr + 5'd1;
                     r_state <= S_RD;
                  end
               end else if (w_ptr_hit) begin
                  // Core overwrote the register under refresh; the buffer is stale.
                  r_state <= S_RD;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vscale_regfile_refresh.sv
// Randomised bench for the share-refresh scheduler with a behavioural register file and
// an unmasked-value reference model.
module tb_vscale_regfile_refresh;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [4:0]  core_ra2 = 5'd0;
   logic        core_ra2_valid = 1'b0;
   logic        core_wen = 1'b0;
   logic [4:0]  core_wa = 5'd0;
   logic [63:0] core_wd = 64'd0;
   logic [4:0]  rf_ra2;
   logic [63:0] rf_rd2;
   logic        rf_wen;
   logic [4:0]  rf_wa;
   logic [63:0] rf_wd;
   logic [31:0] rnd = 32'd1;
   logic        rnd_valid = 1'b0;
   logic        rnd_ready;
   logic        core_stall;
   logic        busy;
   logic        sweep_done;

   vscale_regfile_refresh #(
      .XPR_LEN(32), .SHARES(2), .REFRESH_INTERVAL(4), .STARVE_LIMIT(16)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .core_ra2(core_ra2), .core_ra2_valid(core_ra2_valid),
      .core_wen(core_wen), .core_wa(core_wa), .core_wd(core_wd),
      .rf_ra2(rf_ra2), .rf_rd2(rf_rd2), .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
      .core_stall(core_stall), .busy(busy), .sweep_done(sweep_done)
   );

   always #5 clk = ~clk;

   logic [63:0] rf_mem [32];
   logic [31:0] golden [32];
   assign rf_rd2 = (rf_ra2 == 5'd0) ? 64'd0 : rf_mem[rf_ra2];
   always @(posedge clk) if (rf_wen && rf_wa != 5'd0) rf_mem[rf_wa] <= rf_wd;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_done = 0;
   logic [4:0]  exp_ptr = 5'd1;
   logic [4:0]  last_ref_wa = 5'd0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      rnd = $urandom | 32'h1;
   endtask

   // Reference: refresh writes walk x1..x31 in order, re-mask the current contents and keep
   // each register's unmasked value equal to the last value the core wrote.
   always @(negedge clk) begin
      if (!reset) begin
         if (rnd_ready) begin
            check_eq("ref_wen", rf_wen, 1);
            check_eq("ref_addr", rf_wa, exp_ptr);
            check_eq("ref_data", rf_wd, rf_mem[rf_wa] ^ {rnd, rnd});
            check_eq("ref_unmasked", rf_wd[31:0] ^ rf_wd[63:32], golden[rf_wa]);
            last_ref_wa = rf_wa;
            exp_ptr = (exp_ptr == 5'd31) ? 5'd1 : exp_ptr + 5'd1;
         end else if (core_wen && !core_stall && core_wa != 5'd0) begin
            golden[core_wa] = core_wd[31:0] ^ core_wd[63:32];
         end
         if (sweep_done) n_done++;
         if (!busy) exp_ptr = 5'd1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int nd0;
      logic [63:0] snap5;

      // Reset state and pass-through
      #1;
      reset = 1'b1;
      core_ra2 = 5'd13; core_wen = 1'b1; core_wa = 5'd22; core_wd = {$urandom, $urandom};
      #2;
      check_eq("rst_stall", core_stall, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", sweep_done, 0);
      check_eq("rst_rnd_ready", rnd_ready, 0);
      check_eq("rst_pass_ra2", rf_ra2, 13);
      check_eq("rst_pass_wen", rf_wen, 1);
      check_eq("rst_pass_wa", rf_wa, 22);
      check_eq("rst_pass_wd", rf_wd, core_wd);
      step(); step();
      reset = 1'b0;
      core_wen = 1'b0;

      // Load x1..x31 through the core port while refresh is disabled
      for (int r = 1; r < 32; r++) begin
         core_wen = 1'b1;
         core_wa  = 5'(r);
         core_wd  = (r == 5) ? 64'h12345678_00000000 : {$urandom, $urandom};
         step();
      end
      core_wen = 1'b0;
      step();
      snap5 = rf_mem[5];
      check_eq("init_x5", snap5, 64'h12345678_00000000);

      // Uncontended sweep
      enable = 1'b1; rnd_valid = 1'b1;
      n = 0;
      while (!busy && n < 50) begin step(); n++; end
      check_eq("sweep_start_cycles", n, 5);
      nd0 = n_done;
      n = 0;
      while (!sweep_done && n < 200) begin step(); n++; end
      check_eq("sweep_len_cycles", n, 62);
      enable = 1'b0;
      step();
      check_eq("done_pulses", n_done - nd0, 1);
      check_eq("done_clear", sweep_done, 0);
      check_eq("idle_busy", busy, 0);
      for (int r = 1; r < 32; r++)
         check_eq("sweep_unmasked", rf_mem[r][31:0] ^ rf_mem[r][63:32], golden[r]);
      check_eq("x5_remasked", rf_mem[5] != snap5, 1);

      // Starvation on the read port, then on the write port
      core_ra2_valid = 1'b1; core_ra2 = 5'($urandom);
      enable = 1'b1;
      n = 0;
      while (!busy && n < 50) begin step(); n++; end
      check_eq("sweep2_start_cycles", n, 5);
      n = 0;
      while (!core_stall && n < 60) begin step(); n++; end
      check_eq("starve_rd_cycles", n, 16);
      check_eq("stall_owns_ra2", rf_ra2, 1);
      step();
      check_eq("stall_rd_release", core_stall, 0);
      core_ra2_valid = 1'b0; core_wen = 1'b1; core_wa = 5'd0; core_wd = {$urandom, $urandom};
      n = 0;
      while (!core_stall && n < 60) begin step(); n++; end
      check_eq("starve_wr_cycles", n, 16);
      check_eq("stall_wr_fire", rnd_ready, 1);
      step();
      check_eq("stall_wr_release", core_stall, 0);
      core_wen = 1'b0;

      // Core overwrites x7 while its refresh write is pending
      n = 0;
      while (last_ref_wa != 5'd6 && n < 100) begin step(); n++; end
      check_eq("reach_x6", last_ref_wa, 6);
      rnd_valid = 1'b0;
      step();
      check_eq("wr7_hold", rnd_ready, 0);
      core_wen = 1'b1; core_wa = 5'd7; core_wd = 64'hAAAAAAAA_55555555;
      #1;
      check_eq("hz_no_refresh", rnd_ready, 0);
      check_eq("hz_core_wa", rf_wa, 7);
      step();
      core_wen = 1'b0; core_ra2 = 5'd3; core_ra2_valid = 1'b0;
      #1;
      check_eq("hz_reread_x7", rf_ra2, 7);
      step();
      // Randomness unavailable for 20 cycles while the write is pending
      for (int i = 0; i < 20; i++) begin
         check_eq("norand_ready", rnd_ready, 0);
         check_eq("norand_stall", core_stall, 0);
         check_eq("norand_wen", rf_wen, 0);
         step();
      end
      rnd_valid = 1'b1;
      #1;
      check_eq("rand_fire", rnd_ready, 1);
      check_eq("rand_fire_wa", rf_wa, 7);
      step();
      check_eq("x7_unmasked", rf_mem[7][31:0] ^ rf_mem[7][63:32], 32'hFFFFFFFF);

      // Enable dropped in RD at x10, then restart from x1
      n = 0;
      while (last_ref_wa != 5'd9 && n < 100) begin step(); n++; end
      check_eq("reach_x9", last_ref_wa, 9);
      enable = 1'b0;
      #1;
      check_eq("rd10_ra2", rf_ra2, 10);
      step();
      check_eq("abort_busy", busy, 0);
      check_eq("abort_no_write", rnd_ready, 0);
      check_eq("abort_pass_ra2", rf_ra2, core_ra2);
      enable = 1'b1;
      n = 0;
      while (!busy && n < 50) begin step(); n++; end
      check_eq("restart_cycles", n, 5);
      n = 0;
      while (last_ref_wa == 5'd9 && n < 20) begin step(); n++; end
      check_eq("restart_ptr", last_ref_wa, 1);

      // Reset while a write is pending
      rnd_valid = 1'b0;
      step();
      check_eq("pre_rst_busy", busy, 1);
      reset = 1'b1;
      #1;
      check_eq("rst_wr_wen", rf_wen, 0);
      check_eq("rst_wr_busy", busy, 0);
      check_eq("rst_wr_stall", core_stall, 0);
      check_eq("rst_wr_rnd_ready", rnd_ready, 0);
      check_eq("rst_wr_done", sweep_done, 0);
      step();
      reset = 1'b0; enable = 1'b0; core_ra2 = 5'($urandom);
      #1;
      check_eq("post_rst_pass_ra2", rf_ra2, core_ra2);
      for (int r = 1; r < 32; r++)
         check_eq("final_unmasked", rf_mem[r][31:0] ^ rf_mem[r][63:32], golden[r]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
